// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the five-stage core hazard controller:
//   - hz_state_e     : controller FSM states (RUN, MEM_WAIT, REDIRECT)
//   - CSR_RET_*      : encodings of the EXE-stage exe_csr_ret field
//   - REG_ZERO       : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

  localparam logic [1:0] CSR_RET_NONE = 2'b00;
  localparam logic [1:0] CSR_RET_XRET = 2'b01;
  localparam logic [1:0] CSR_RET_TRAP = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_load_use.sv
// ---------------------------------------------------------------------------
// hazard_load_use
// Combinational load-use detector: flags when the load in EXE writes a
// register that the instruction in ID actually reads. Writes to x0 never
// create a dependency.
// Ports:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2 : ID-stage operand info
//   exe_valid, exe_rd, exe_mem_read                  : EXE-stage load info
//   load_use                                         : hazard detected
// ---------------------------------------------------------------------------
module hazard_load_use
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       exe_valid,
  input  logic [4:0] exe_rd,
  input  logic       exe_mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == exe_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == exe_rd);
  assign load_use = exe_valid && exe_mem_read && (exe_rd != REG_ZERO) &&
                    id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush generator for the five-stage core. Detects load-use
// hazards (ID vs EXE), resolves branch mispredicts and CSR traps/xRETs raised
// in EXE, and freezes the whole pipe during multi-cycle data-memory accesses.
// All outputs are combinational from inputs and FSM state.
// Priority: memory wait > trap/xRET > mispredict > load-use.
// Optional feature macro: PIPE_HAZARD_PERF_EN adds 64-bit perf counters.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   id_*                          : ID-stage operand usage
//   exe_*                         : EXE-stage load/branch/CSR status
//   mem_req, mem_ack              : MEM-stage data access handshake
//   pc_stall, *_stall, *_flush    : pipeline register controls
//   redirect_valid                : PC mux takes EXE-supplied target
//   perf_stall_cycles             : cycles with pc_stall (PERF only)
//   perf_flush_events             : cycles with redirect_valid (PERF only)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        exe_valid,
  input  logic [4:0]  exe_rd,
  input  logic        exe_mem_read,
  input  logic        exe_br_mispredict,
  input  logic [1:0]  exe_csr_ret,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EXE_stall,
  output logic        ID_EXE_flush,
  output logic        EXE_MEM_stall,
  output logic        EXE_MEM_flush,
  output logic        MEM_WB_stall,
  output logic        MEM_WB_flush,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [63:0] perf_stall_cycles,
  output logic [63:0] perf_flush_events,
`endif
  output logic        redirect_valid
);

  hz_state_e state_q;
  hz_state_e state_d;

  logic load_use;
  logic mem_waiting;
  logic is_trap;
  logic is_xret;
  logic is_mispredict;

  hazard_load_use u_load_use (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .exe_valid    (exe_valid),
    .exe_rd       (exe_rd),
    .exe_mem_read (exe_mem_read),
    .load_use     (load_use)
  );

  // Once in MEM_WAIT the freeze lasts until the ack, even if mem_req wobbles.
  assign mem_waiting   = (mem_req || (state_q == ST_MEM_WAIT)) && !mem_ack;
  assign is_trap       = exe_valid && (exe_csr_ret == CSR_RET_TRAP);
  assign is_xret       = exe_valid && (exe_csr_ret == CSR_RET_XRET);
  assign is_mispredict = exe_valid && exe_br_mispredict;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_stall       = 1'b0;
    IF_ID_stall    = 1'b0;
    IF_ID_flush    = 1'b0;
    ID_EXE_stall   = 1'b0;
    ID_EXE_flush   = 1'b0;
    EXE_MEM_stall  = 1'b0;
    EXE_MEM_flush  = 1'b0;
    MEM_WB_stall   = 1'b0;
    MEM_WB_flush   = 1'b0;
    redirect_valid = 1'b0;

    if (rst) begin
      // Empty every pipeline register while reset is held.
      state_d       = ST_RUN;
      IF_ID_flush   = 1'b1;
      ID_EXE_flush  = 1'b1;
      EXE_MEM_flush = 1'b1;
      MEM_WB_flush  = 1'b1;
    end else if (mem_waiting) begin
      state_d       = ST_MEM_WAIT;
      pc_stall      = 1'b1;
      IF_ID_stall   = 1'b1;
      ID_EXE_stall  = 1'b1;
      EXE_MEM_stall = 1'b1;
      MEM_WB_stall  = 1'b1;
    end else if (state_q == ST_REDIRECT) begin
      // The instruction fetched during the redirect cycle raced the CSR
      // vector/epc read, so it is discarded as well.
      state_d     = ST_RUN;
      IF_ID_flush = 1'b1;
    end else begin
      state_d = ST_RUN;
      if (is_trap || is_xret) begin
        state_d        = ST_REDIRECT;
        IF_ID_flush    = 1'b1;
        ID_EXE_flush   = 1'b1;
        // A trap kills the faulting instruction; an xRET retires normally.
        EXE_MEM_flush  = is_trap;
        redirect_valid = 1'b1;
      end else if (is_mispredict) begin
        IF_ID_flush    = 1'b1;
        ID_EXE_flush   = 1'b1;
        redirect_valid = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, insert a bubble into EXE.
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EXE_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 64'd0;
      perf_flush_events <= 64'd0;
    end else begin
      if (pc_stall) begin
        perf_stall_cycles <= perf_stall_cycles + 64'd1;
      end
      if (redirect_valid) begin
        perf_flush_events <= perf_flush_events + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Table-driven single-cycle vectors (applied in RUN) plus hand-written
// multi-cycle sequences for memory wait, trap/xRET redirect and reset.
// Output vector bit order:
//   {pc_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_flush,
//    EXE_MEM_stall, EXE_MEM_flush, MEM_WB_stall, MEM_WB_flush, redirect_valid}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] O_LU    = 10'b11_0010_0000;
  localparam logic [9:0] O_MP    = 10'b00_1010_0001;
  localparam logic [9:0] O_TRAP  = 10'b00_1010_1001;
  localparam logic [9:0] O_XRET  = 10'b00_1010_0001;
  localparam logic [9:0] O_RDR   = 10'b00_1000_0000;
  localparam logic [9:0] O_STALL = 10'b11_0101_0100;
  localparam logic [9:0] O_RST   = 10'b00_1010_1010;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic       exe_valid;
  logic [4:0] exe_rd;
  logic       exe_mem_read, exe_br_mispredict;
  logic [1:0] exe_csr_ret;
  logic       mem_req, mem_ack;
  logic       pc_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_flush;
  logic       EXE_MEM_stall, EXE_MEM_flush, MEM_WB_stall, MEM_WB_flush;
  logic       redirect_valid;
`ifdef PIPE_HAZARD_PERF_EN
  logic [63:0] perf_stall_cycles, perf_flush_events;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .exe_valid         (exe_valid),
    .exe_rd            (exe_rd),
    .exe_mem_read      (exe_mem_read),
    .exe_br_mispredict (exe_br_mispredict),
    .exe_csr_ret       (exe_csr_ret),
    .mem_req           (mem_req),
    .mem_ack           (mem_ack),
    .pc_stall          (pc_stall),
    .IF_ID_stall       (IF_ID_stall),
    .IF_ID_flush       (IF_ID_flush),
    .ID_EXE_stall      (ID_EXE_stall),
    .ID_EXE_flush      (ID_EXE_flush),
    .EXE_MEM_stall     (EXE_MEM_stall),
    .EXE_MEM_flush     (EXE_MEM_flush),
    .MEM_WB_stall      (MEM_WB_stall),
    .MEM_WB_flush      (MEM_WB_flush),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events),
`endif
    .redirect_valid    (redirect_valid)
  );

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic [4:0] rd;
    logic       ld;
    logic       mp;
    logic [1:0] csr;
    logic       mreq;
    logic       mack;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [9:0] outs();
    return {pc_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_flush,
            EXE_MEM_stall, EXE_MEM_flush, MEM_WB_stall, MEM_WB_flush,
            redirect_valid};
  endfunction

  task automatic drive(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic exv,
                       input logic [4:0] rd, input logic ld, input logic mp,
                       input logic [1:0] csr, input logic mreq, input logic mack);
    id_valid = idv; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    exe_valid = exv; exe_rd = rd; exe_mem_read = ld; exe_br_mispredict = mp;
    exe_csr_ret = csr; mem_req = mreq; mem_ack = mack;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Let inputs settle (#1), compare outputs, then advance to 1ns past the edge.
  task automatic check(input string name, input logic [9:0] exp);
    #1;
    checks++;
    if (outs() !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, outs(), exp);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
`endif

  initial begin
    //               name          idv rs1 rs2 u1 u2 exv rd ld mp csr   mreq mack exp
    vecs[0]  = '{"idle",           0,  0,  0,  0, 0, 0,  0, 0, 0, 2'b00, 0, 0, O_NONE};
    vecs[1]  = '{"lu_rs2_x5",      1,  1,  5,  1, 1, 1,  5, 1, 0, 2'b00, 0, 0, O_LU};
    vecs[2]  = '{"lu_rs1_x5",      1,  5,  2,  1, 0, 1,  5, 1, 0, 2'b00, 0, 0, O_LU};
    vecs[3]  = '{"lu_rs2_unused",  1,  1,  5,  1, 0, 1,  5, 1, 0, 2'b00, 0, 0, O_NONE};
    vecs[4]  = '{"lu_x0",          1,  0,  0,  1, 1, 1,  0, 1, 0, 2'b00, 0, 0, O_NONE};
    vecs[5]  = '{"lu_id_invalid",  0,  5,  5,  1, 1, 1,  5, 1, 0, 2'b00, 0, 0, O_NONE};
    vecs[6]  = '{"alu_not_load",   1,  5,  5,  1, 1, 1,  5, 0, 0, 2'b00, 0, 0, O_NONE};
    vecs[7]  = '{"lu_exe_invalid", 1,  5,  5,  1, 1, 0,  5, 1, 0, 2'b00, 0, 0, O_NONE};
    vecs[8]  = '{"lu_rd_differs",  1,  6,  7,  1, 1, 1,  5, 1, 0, 2'b00, 0, 0, O_NONE};
    vecs[9]  = '{"mispredict",     0,  0,  0,  0, 0, 1,  3, 0, 1, 2'b00, 0, 0, O_MP};
    vecs[10] = '{"mp_plus_lu",     1,  9,  0,  1, 0, 1,  9, 1, 1, 2'b00, 0, 0, O_MP};
    vecs[11] = '{"csr_reserved",   0,  0,  0,  0, 0, 1,  0, 0, 0, 2'b11, 0, 0, O_NONE};
    vecs[12] = '{"mp_exe_invalid", 0,  0,  0,  0, 0, 0,  0, 0, 1, 2'b00, 0, 0, O_NONE};
    vecs[13] = '{"lu_with_ack",    1,  4,  0,  1, 0, 1,  4, 1, 0, 2'b00, 1, 1, O_LU};

    rst = 1'b1;
    idle();
    check("reset_outputs", O_RST);
    check("reset_outputs_2", O_RST);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].idv, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].exv, vecs[i].rd, vecs[i].ld, vecs[i].mp, vecs[i].csr,
            vecs[i].mreq, vecs[i].mack);
      check(vecs[i].name, vecs[i].exp);
    end

    // Load-use bubble lasts one cycle: load moves on, EXE holds the bubble.
    drive(1, 1, 5, 1, 1, 1, 5, 1, 0, 2'b00, 0, 0);
    check("lu_seq_bubble", O_LU);
    drive(1, 1, 5, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    check("lu_seq_after", O_NONE);

    // Three-cycle memory wait with a held load-use pair that resolves on ack.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5, 1, 1, 1, 5, 1, 0, 2'b00, 1, 0);
      check($sformatf("memwait_%0d", i), O_STALL);
    end
    drive(1, 1, 5, 1, 1, 1, 5, 1, 0, 2'b00, 1, 1);
    check("memwait_ack_lu", O_LU);
    idle();
    check("memwait_done", O_NONE);

    // Memory wait overrides a mispredict; held mispredict fires on ack.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 1, 0);
    check("memwait_over_mp", O_STALL);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 0, 1);
    check("ack_mp", O_MP);

    // Trap: three flushes + redirect, then one REDIRECT cycle that ignores EXE.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0);
    check("trap", O_TRAP);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 0, 0);
    check("trap_redirect", O_RDR);
    idle();
    check("trap_back_run", O_NONE);

    // xRET keeps the EXE/MEM entry.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0);
    check("xret", O_XRET);
    idle();
    check("xret_redirect", O_RDR);
    idle();
    check("xret_back_run", O_NONE);

    // Trap resolving in the mem_ack cycle still enters REDIRECT.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0);
    check("trap_in_wait", O_STALL);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 1);
    check("trap_on_ack", O_TRAP);
    idle();
    check("trap_on_ack_rdr", O_RDR);

    // Memory wait beginning in the REDIRECT cycle takes priority.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0);
    check("trap_b", O_TRAP);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    check("rdr_memwait", O_STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1);
    check("rdr_memwait_ack", O_NONE);

    // Reset during MEM_WAIT: RUN afterwards (mem_req low gives no stall).
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    check("enter_memwait", O_STALL);
    rst = 1'b1;
    check("rst_in_memwait", O_RST);
    rst = 1'b0;
    idle();
    check("after_rst_memwait", O_NONE);

    // Reset during REDIRECT: no pending IF/ID flush afterwards.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0);
    check("trap_c", O_TRAP);
    rst = 1'b1;
    idle();
    check("rst_in_redirect", O_RST);
    rst = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
    check64("perf_stall_zero", perf_stall_cycles, 64'd0);
    check64("perf_flush_zero", perf_flush_events, 64'd0);
`endif
    check("after_rst_redirect", O_NONE);

`ifdef PIPE_HAZARD_PERF_EN
    drive(1, 1, 5, 1, 1, 1, 5, 1, 0, 2'b00, 0, 0);
    check("perf_lu", O_LU);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 0, 0);
    check("perf_mp", O_MP);
    check64("perf_stall_one", perf_stall_cycles, 64'd1);
    check64("perf_flush_one", perf_flush_events, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush generator for the five-stage core: produces the stall and flush controls consumed by the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and the PC register. It detects load-use hazards between ID and EXE, resolves branch mispredictions and CSR traps/returns raised in EXE, and freezes the whole pipe during multi-cycle data-memory accesses.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source register indices
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- exe_valid  in  1  EXE holds a real instruction
- exe_rd  in  5  EXE destination register
- exe_mem_read  in  1  EXE instruction is a load
- exe_br_mispredict  in  1  EXE branch outcome differs from fetch path
- exe_csr_ret  in  2  00 none, 01 xRET, 10 trap (ecall/illegal), 11 reserved (treated as none)
- mem_req  in  1  MEM stage has a data access outstanding
- mem_ack  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- IF_ID_stall, IF_ID_flush  out  1 each
- ID_EXE_stall, ID_EXE_flush  out  1 each
- EXE_MEM_stall, EXE_MEM_flush  out  1 each
- MEM_WB_stall, MEM_WB_flush  out  1 each
- redirect_valid  out  1  PC mux selects EXE-supplied target (branch or CSR vector/epc)

## Operation
- FSM states: RUN, MEM_WAIT, REDIRECT. Reset state RUN.
- Outputs are combinational from inputs + state; only state (and perf counters) are registered.
- Priority within a cycle: memory wait > trap/xRET > mispredict > load-use.
- Memory wait: mem_req && !mem_ack -> all five stalls = 1, all flushes = 0, redirect_valid = 0; next state MEM_WAIT. Stays while !mem_ack. In the mem_ack cycle stalls drop and the remaining rules evaluate normally on held EXE/ID inputs; next state RUN (or REDIRECT per trap rule).
- Trap/xRET (exe_valid && exe_csr_ret in {01,10}): IF_ID_flush, ID_EXE_flush, EXE_MEM_flush = 1 (trap only; xRET leaves EXE_MEM_flush = 0), redirect_valid = 1; next state REDIRECT.
- REDIRECT (one cycle): IF_ID_flush = 1 (covers CSR vector read latency), all else 0; next state RUN unless a memory wait begins.
- Mispredict (exe_valid && exe_br_mispredict): IF_ID_flush, ID_EXE_flush, redirect_valid = 1; state stays RUN.
- Load-use: exe_valid && exe_mem_read && exe_rd != 0 && id_valid && ((id_use_rs1 && id_rs1 == exe_rd) || (id_use_rs2 && id_rs2 == exe_rd)) -> pc_stall, IF_ID_stall, ID_EXE_flush = 1 for exactly one cycle (bubble inserted).
- Load-use suppressed whenever mispredict or trap fires the same cycle.
- Stall and flush never both asserted on the same register.

## Timing
- rst high: state <- RUN; all flushes = 1, all stalls = 0, redirect_valid = 0 combinationally while rst is high; perf counters <- 0.
- Hazard response is zero-cycle (same cycle as inputs); pipeline registers apply it at the next clk edge.
- Load-use costs exactly one bubble; mispredict costs two; trap costs three (two flushes + REDIRECT).
- rst asserted in MEM_WAIT or REDIRECT: state is RUN on the following cycle, no pending redirect retained.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds outputs perf_stall_cycles [63:0] (cycles with pc_stall = 1) and perf_flush_events [63:0] (cycles with redirect_valid = 1); both increment by 1, wrap at 2^64, clear on rst.
- Undefined: ports and counters absent; control behaviour identical.

## Structure
- Shared package/header: FSM state encodings, CSR_RET_NONE/XRET/TRAP constants, REG_ZERO = 5'd0.
- One sub-module: hazard_load_use (combinational register-match compare), instantiated once.

## Test plan
- Load x5 in EXE, ID add reads rs2 = x5 -> pc_stall/IF_ID_stall/ID_EXE_flush = 1 for one cycle, then 0.
- Load to x0 in EXE, ID reads x0 -> no stall, no flush.
- mem_req = 1, mem_ack low for 3 cycles -> all stalls = 1 for 3 cycles, drop in ack cycle.
- exe_csr_ret = 10 -> IF_ID/ID_EXE/EXE_MEM flush + redirect_valid, next cycle IF_ID_flush only, then RUN.
- Mispredict and load-use same cycle -> flushes + redirect, pc_stall = 0.
- rst pulsed during MEM_WAIT -> all flushes = 1 during rst, state RUN after, PIPE_HAZARD_PERF_EN counters read 0.
